mem_lsu: RTL and testbench

Parametrised MEM-stage load/store unit for the tinyMIPS five-stage pipeline, sitting between EX/MEM and MEM/WB. It carries ALU/HI-LO results through unchanged and executes LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC over a Wishbone-style bus with wait states. It stalls the pipeline while a bus cycle is outstanding and detects misalignment and bus errors or timeouts. It also maintains the LL/SC link bit.

---
 rtl/mem_lsu_pkg.sv | 62 ++++++
 rtl/mem_load_fmt.sv | 36 +++
 rtl/mem_lsu.sv | 214 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, widths and decode helpers for the tinyMIPS MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int unsigned RegW     = 32;
  localparam int unsigned RegAddrW = 5;

  localparam logic [RegW-1:0] ZeroWord     = '0;
  localparam logic            WriteEnable  = 1'b1;
  localparam logic            WriteDisable = 1'b0;
  localparam logic            ChipEnable   = 1'b1;
  localparam logic            ChipDisable  = 1'b0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StDone
  } lsu_state_e;

  function automatic logic is_load(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: is_store = 1'b1;
      default: is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_byte(input logic [7:0] op);
    is_byte = (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP);
  endfunction

  function automatic logic is_half(input logic [7:0] op);
    is_half = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    if (is_byte(op)) begin
      misaligned = 1'b0;
    end else if (is_half(op)) begin
      misaligned = addr_lo[0];
    end else begin
      misaligned = (addr_lo != 2'b00);
    end
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Extracts and extends the addressed byte/halfword (big-endian lanes) from a latched bus word.
module mem_load_fmt
  import mem_lsu_pkg::*;
(
  input  logic [7:0]      i_aluop,
  input  logic [1:0]      i_addr_lo,
  input  logic [RegW-1:0] i_word,
  output logic [RegW-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[31:24];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[15:0] : i_word[31:16];
  end

  always_comb begin
    o_result = i_word;
    case (i_aluop)
      EXE_LB_OP:  o_result = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: o_result = {24'h0, w_byte};
      EXE_LH_OP:  o_result = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: o_result = {16'h0, w_half};
      default:    o_result = i_word;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes ALU results through, runs one Wishbone-style access per
// memory op with pipeline stall, alignment/bus-error detection and the LL/SC link bit.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LLSC_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [RegAddrW-1:0] wd_i,
  input  logic                wreg_i,
  input  logic [RegW-1:0]     wdata_i,
  input  logic                whilo_i,
  input  logic [RegW-1:0]     hi_i,
  input  logic [RegW-1:0]     lo_i,
  input  logic [7:0]          aluop_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [RegW-1:0]     reg2_i,
  output logic [RegAddrW-1:0] wd_o,
  output logic                wreg_o,
  output logic [RegW-1:0]     wdata_o,
  output logic                whilo_o,
  output logic [RegW-1:0]     hi_o,
  output logic [RegW-1:0]     lo_o,
  output logic                stall_req_o,
  output logic                bus_cyc_o,
  output logic                bus_stb_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [3:0]          bus_sel_o,
  output logic [31:0]         bus_data_o,
  input  logic [31:0]         bus_data_i,
  input  logic                bus_ack_i,
  input  logic                bus_err_i,
  output logic                excp_align_o,
  output logic                excp_bus_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e r_state, w_state_d;

  logic              r_cyc, r_we, r_abort, r_flush, r_excp_bus, r_llbit, w_llbit_d;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [3:0]        r_sel, w_sel;
  logic [31:0]       r_data, w_sdata, r_word;
  logic [CntW-1:0]   r_cnt;
  logic [RegW-1:0]   w_load;
  logic              w_mem, w_misal, w_is_sc, w_is_ll, w_sc_fail, w_start, w_timeout, w_abort;

  assign w_mem     = valid_i && (is_load(aluop_i) || is_store(aluop_i));
  assign w_misal   = misaligned(aluop_i, mem_addr_i[1:0]);
  assign w_is_sc   = (aluop_i == EXE_SC_OP);
  assign w_is_ll   = (aluop_i == EXE_LL_OP);
  assign w_sc_fail = (LLSC_EN != 0) && w_is_sc && !r_llbit;
  assign w_start   = (r_state == StIdle) && w_mem && !flush_i && !w_misal && !w_sc_fail;
  assign w_addr    = ADDR_W'({mem_addr_i[31:2], 2'b00});
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CntW'(TIMEOUT - 1));
  // Error beats ack; ack in the final allowed cycle still counts as success.
  assign w_abort   = (r_state == StBus) && (bus_err_i || (!bus_ack_i && w_timeout));

  always_comb begin
    if (is_byte(aluop_i)) begin
      w_sel   = 4'b1000 >> mem_addr_i[1:0];
      w_sdata = {4{reg2_i[7:0]}};
    end else if (is_half(aluop_i)) begin
      w_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      w_sdata = {2{reg2_i[15:0]}};
    end else begin
      w_sel   = 4'b1111;
      w_sdata = reg2_i;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_d = StBus;
      StBus:   if (bus_ack_i || w_abort) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_llbit_d = r_llbit;
    if ((r_state == StBus) && bus_ack_i && !w_abort && !flush_i && !r_flush) begin
      if (w_is_ll) w_llbit_d = 1'b1;
      if (w_is_sc) w_llbit_d = 1'b0;
    end
    if (flush_i || (LLSC_EN == 0)) w_llbit_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_llbit    <= 1'b0;
      r_excp_bus <= 1'b0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_sel      <= '0;
      r_data     <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
      r_abort    <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_llbit    <= w_llbit_d;
      r_excp_bus <= w_abort;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_cyc   <= 1'b1;
            r_we    <= is_store(aluop_i);
            r_addr  <= w_addr;
            r_sel   <= w_sel;
            r_data  <= w_sdata;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_flush <= 1'b0;
          end
        end
        StBus: begin
          if (TIMEOUT != 0) r_cnt <= r_cnt + 1'b1;
          if (flush_i) r_flush <= 1'b1;
          if (w_abort) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_abort <= 1'b1;
          end else if (bus_ack_i) begin
            r_cyc  <= 1'b0;
            r_we   <= 1'b0;
            r_word <= bus_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  mem_load_fmt u_load_fmt (
    .i_aluop   (aluop_i),
    .i_addr_lo (mem_addr_i[1:0]),
    .i_word    (r_word),
    .o_result  (w_load)
  );

  always_comb begin
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    whilo_o      = whilo_i;
    hi_o         = hi_i;
    lo_o         = lo_i;
    stall_req_o  = 1'b0;
    excp_align_o = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_mem) begin
          if (flush_i) begin
            wreg_o = WriteDisable;
          end else if (w_misal) begin
            excp_align_o = 1'b1;
            wreg_o       = WriteDisable;
          end else if (w_sc_fail) begin
            wdata_o = ZeroWord;
          end else begin
            stall_req_o = 1'b1;
            wreg_o      = WriteDisable;
          end
        end
      end
      StBus: begin
        stall_req_o = 1'b1;
        wreg_o      = WriteDisable;
      end
      StDone: begin
        wreg_o = wreg_i && !r_abort && !r_flush && !flush_i;
        if (w_is_sc) begin
          wdata_o = 32'd1;
        end else if (is_load(aluop_i)) begin
          wdata_o = w_load;
        end
      end
      default: ;
    endcase
    // Hold every pipeline-facing output at zero while reset is asserted.
    if (!rst_n) begin
      wd_o         = '0;
      wreg_o       = 1'b0;
      wdata_o      = ZeroWord;
      whilo_o      = 1'b0;
      hi_o         = ZeroWord;
      lo_o         = ZeroWord;
      stall_req_o  = 1'b0;
      excp_align_o = 1'b0;
    end
  end

  assign bus_cyc_o  = r_cyc;
  assign bus_stb_o  = r_cyc;
  assign bus_we_o   = r_we;
  assign bus_addr_o = r_addr;
  assign bus_sel_o  = r_sel;
  assign bus_data_o = r_data;
  assign excp_bus_o = r_excp_bus;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, load/store lanes, alignment, LL/SC, errors, timeout.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam logic [7:0] AluAdd = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, flush_i = 1'b0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0, whilo_i = 1'b0;
  logic [31:0] wdata_i = '0, hi_i = '0, lo_i = '0, mem_addr_i = '0, reg2_i = '0;
  logic [7:0]  aluop_i = '0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stall_req_o, bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] wdata_o, hi_o, lo_o, bus_addr_o, bus_data_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0, bus_err_i = 1'b0;
  logic        excp_align_o, excp_bus_o;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .TIMEOUT(4), .LLSC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .stall_req_o(stall_req_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
    .excp_align_o(excp_align_o), .excp_bus_o(excp_bus_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus slave: responds in the ack_after-th cycle of an active bus cycle.
  int          ack_after = 1;
  bit          resp_err = 0, resp_none = 0;
  logic [31:0] resp_word = '0;
  int          bcnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus_cyc_o) bcnt++;
      else bcnt = 0;
      bus_ack_i  = bus_cyc_o && !resp_none && !resp_err && (bcnt == ack_after);
      bus_err_i  = bus_cyc_o && !resp_none && resp_err && (bcnt == ack_after);
      bus_data_i = resp_word;
    end
  end

  int          obs_stalls, obs_cyc;
  logic [3:0]  obs_sel;
  logic [31:0] obs_bdata, obs_wdata;
  logic        obs_we, obs_wreg, obs_xbus, obs_xalign;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op at posedge+1 and follows it until stall_req_o drops, sampling at negedges.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic wr);
    bit done;
    done       = 0;
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = r2;
    wreg_i     = wr;
    wd_i       = 5'd7;
    wdata_i    = 32'hDEAD_0000;
    valid_i    = 1'b1;
    obs_stalls = 0;
    obs_cyc    = 0;
    obs_sel    = '0;
    obs_bdata  = '0;
    obs_we     = 1'b0;
    obs_xbus   = 1'b0;
    obs_xalign = 1'b0;
    obs_wdata  = '0;
    obs_wreg   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus_cyc_o) begin
        obs_cyc++;
        obs_sel   = bus_sel_o;
        obs_bdata = bus_data_o;
        obs_we    = bus_we_o;
      end
      if (excp_bus_o) obs_xbus = 1'b1;
      if (!stall_req_o) begin
        obs_wdata  = wdata_o;
        obs_wreg   = wreg_o;
        obs_xalign = excp_align_o;
        done       = 1;
      end else begin
        obs_stalls++;
      end
      tick();
    end
    if (!done) check_eq("op_completes", 32'd0, 32'd1);
    valid_i = 1'b0;
  endtask

  initial begin
    // Reset holds outputs at zero even with a valid op presented.
    valid_i = 1'b1; aluop_i = AluAdd; wreg_i = 1'b1; wdata_i = 32'h55; wd_i = 5'd9;
    tick(); tick();
    @(negedge clk);
    check_eq("rst_wdata", wdata_o, 32'h0);
    check_eq("rst_wreg", {31'h0, wreg_o}, 32'h0);
    check_eq("rst_stall", {31'h0, stall_req_o}, 32'h0);
    check_eq("rst_cyc", {31'h0, bus_cyc_o}, 32'h0);
    tick();
    rst_n = 1'b1; valid_i = 1'b0;
    tick();

    // ALU pass-through
    valid_i = 1'b1; aluop_i = AluAdd; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234;
    whilo_i = 1'b1; hi_i = 32'hAAAA_0001; lo_i = 32'h5555_0002;
    @(negedge clk);
    check_eq("add_wdata", wdata_o, 32'h1234);
    check_eq("add_wd", {27'h0, wd_o}, 32'd3);
    check_eq("add_wreg", {31'h0, wreg_o}, 32'd1);
    check_eq("add_stall", {31'h0, stall_req_o}, 32'd0);
    check_eq("add_cyc", {31'h0, bus_cyc_o}, 32'd0);
    check_eq("add_hi", hi_o, 32'hAAAA_0001);
    tick();
    valid_i = 1'b0; whilo_i = 1'b0;

    // LB, ack in second bus cycle
    resp_word = 32'h11F2_3344; ack_after = 2;
    run_op(EXE_LB_OP, 32'h101, 32'h0, 1'b1);
    check_eq("lb_stalls", obs_stalls, 32'd3);
    check_eq("lb_sel", {28'h0, obs_sel}, 32'b0100);
    check_eq("lb_we", {31'h0, obs_we}, 32'd0);
    check_eq("lb_wdata", obs_wdata, 32'hFFFF_FFF2);
    check_eq("lb_wreg", {31'h0, obs_wreg}, 32'd1);

    // LBU / LHU / LH formats
    ack_after = 1; resp_word = 32'h11F2_8344;
    run_op(EXE_LBU_OP, 32'h103, 32'h0, 1'b1);
    check_eq("lbu_wdata", obs_wdata, 32'h0000_0044);
    check_eq("lbu_stalls", obs_stalls, 32'd2);
    run_op(EXE_LHU_OP, 32'h102, 32'h0, 1'b1);
    check_eq("lhu_wdata", obs_wdata, 32'h0000_8344);
    check_eq("lhu_sel", {28'h0, obs_sel}, 32'b0011);
    resp_word = 32'h8001_7F00;
    run_op(EXE_LH_OP, 32'h100, 32'h0, 1'b1);
    check_eq("lh_wdata", obs_wdata, 32'hFFFF_8001);

    // Stores
    run_op(EXE_SH_OP, 32'h102, 32'hABCD_1234, 1'b1);
    check_eq("sh_sel", {28'h0, obs_sel}, 32'b0011);
    check_eq("sh_data", obs_bdata, 32'h1234_1234);
    check_eq("sh_we", {31'h0, obs_we}, 32'd1);
    check_eq("sh_wreg", {31'h0, obs_wreg}, 32'd1);
    run_op(EXE_SB_OP, 32'h103, 32'h0000_005A, 1'b0);
    check_eq("sb_sel", {28'h0, obs_sel}, 32'b0001);
    check_eq("sb_data", obs_bdata, 32'h5A5A_5A5A);

    // Misaligned LW
    run_op(EXE_LW_OP, 32'h6, 32'h0, 1'b1);
    check_eq("lw_mis_align", {31'h0, obs_xalign}, 32'd1);
    check_eq("lw_mis_cyc", obs_cyc, 32'd0);
    check_eq("lw_mis_wreg", {31'h0, obs_wreg}, 32'd0);
    check_eq("lw_mis_stall", obs_stalls, 32'd0);

    // LH with bus error
    resp_err = 1;
    run_op(EXE_LH_OP, 32'h100, 32'h0, 1'b1);
    check_eq("lh_err_xbus", {31'h0, obs_xbus}, 32'd1);
    check_eq("lh_err_wreg", {31'h0, obs_wreg}, 32'd0);
    @(negedge clk);
    check_eq("lh_err_pulse_end", {31'h0, excp_bus_o}, 32'd0);
    tick();
    resp_err = 0;

    // LL / SC
    resp_word = 32'hCAFE_F00D;
    run_op(EXE_LL_OP, 32'h40, 32'h0, 1'b1);
    check_eq("ll_wdata", obs_wdata, 32'hCAFE_F00D);
    run_op(EXE_SC_OP, 32'h40, 32'h77, 1'b1);
    check_eq("sc1_cyc", obs_cyc, 32'd1);
    check_eq("sc1_data", obs_bdata, 32'h77);
    check_eq("sc1_sel", {28'h0, obs_sel}, 32'hF);
    check_eq("sc1_wdata", obs_wdata, 32'd1);
    run_op(EXE_SC_OP, 32'h40, 32'h78, 1'b1);
    check_eq("sc2_cyc", obs_cyc, 32'd0);
    check_eq("sc2_stall", obs_stalls, 32'd0);
    check_eq("sc2_wdata", obs_wdata, 32'd0);
    run_op(EXE_LL_OP, 32'h40, 32'h0, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    run_op(EXE_SC_OP, 32'h40, 32'h79, 1'b1);
    check_eq("sc_flush_cyc", obs_cyc, 32'd0);
    check_eq("sc_flush_wdata", obs_wdata, 32'd0);

    // Timeout after four bus cycles
    resp_none = 1;
    run_op(EXE_LW_OP, 32'h80, 32'h0, 1'b1);
    check_eq("to_cyc", obs_cyc, 32'd4);
    check_eq("to_stalls", obs_stalls, 32'd5);
    check_eq("to_xbus", {31'h0, obs_xbus}, 32'd1);
    check_eq("to_wreg", {31'h0, obs_wreg}, 32'd0);

    // Reset in the middle of a bus cycle
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h84; wreg_i = 1'b1; valid_i = 1'b1;
    tick(); tick();
    check_eq("mid_in_bus", {31'h0, bus_cyc_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check_eq("mid_rst_cyc", {31'h0, bus_cyc_o}, 32'd0);
    check_eq("mid_rst_stall", {31'h0, stall_req_o}, 32'd0);
    check_eq("mid_rst_sel", {28'h0, bus_sel_o}, 32'd0);
    check_eq("mid_rst_wdata", wdata_o, 32'd0);
    tick();
    valid_i = 1'b0; rst_n = 1'b1; resp_none = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
